id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
Decode-side producer of the ALUOp/Funct pair consumed by the EX-stage ALU control decoder, plus the remaining main-control signals of the 5-stage RISC-V pipeline. The block takes the IF/ID instruction, decodes opcode into control bits, generates the immediate, and registers everything into the ID/EX pipeline register. It owns load-use hazard detection: it inserts bubbles and back-pressures IF/ID. It also honours external stall and flush requests.

Parameters:
XLEN, 64, datapath width of the immediate output
FUNCT_W, 4, width of the Funct field handed to EX; fixed as {instr[30], instr[14:12]}

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
if_id_valid  input  1  IF/ID holds a real instruction
if_id_instr  input  32  instruction word from IF/ID
stall_in  input  1  external hold; ID/EX keeps contents
flush_in  input  1  branch-taken kill; ID/EX becomes bubble
hazard_stall  output  1  combinational; load-use detected, IF/ID and PC must hold
ex_valid  output  1  ID/EX holds a real instruction
ex_ALUOp  output  2  00 add/addr/I-ALU, 01 branch compare (sub), 10 R-type
ex_Funct  output  4  {instr[30], instr[14:12]}
ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  output  1 each  main control bits
ex_rs1, ex_rs2, ex_rd  output  5 each  register specifiers
ex_imm  output  XLEN  sign-extended immediate
ex_illegal  output  1  opcode not in decode table

Behaviour:
- Reset (reset low, async): all ex_* outputs = 0. ex_valid = 0. The counter (if present) = 0. hazard_stall is 0 while ex_valid = 0.
- Latency: 1 cycle from if_id_instr to ex_* outputs.
- Decode table (opcode = instr[6:0]):
  - 0110011 R: ALUOp=10, RegWrite.
  - 0010011 I-ALU: ALUOp=00, ALUSrc, RegWrite.
  - 0000011 load: ALUOp=00, ALUSrc, MemRead, MemtoReg, RegWrite.
  - 0100011 store: ALUOp=00, ALUSrc, MemWrite.
  - 1100011 branch: ALUOp=01, Branch.
  - Other opcodes: all control bits 0, ex_illegal=1.
- Immediate: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}. Sign-extended to XLEN. R-type imm = 0.
- Register specifiers:
  - rs2 is used only by R, store and branch.
  - rs1 is used by all five decoded classes.
  - ex_rd is forced to 0 for store and branch.
- Load-use hazard: hazard = if_id_valid & ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==rs1 | (rs2 used & ex_rd==rs2)). It is gated off when flush_in or stall_in is high.
- Per-edge priority (highest first):
  1. flush_in: ex_valid=0 and all control bits=0.
  2. stall_in: all ex_* registers hold.
  3. hazard: bubble inserted (ex_valid=0, controls 0); hazard_stall=1 this cycle.
  4. Otherwise: load decoded fields; ex_valid=if_id_valid. If if_id_valid=0, control bits load as 0.
- Bubble invariant: ex_valid=0 always implies Branch, MemRead, MemWrite and RegWrite are all 0.
- Back-to-back: a hazard lasts exactly one cycle. The bubble clears ex_MemRead, so the held instruction issues on the following edge.
- Reset mid-stall or mid-hazard: state clears immediately. The first post-reset edge loads normally.

Optional Feature:
- Macro BUBBLE_CNT_EN.
- Defined: adds output bubble_count[15:0]. It increments on every edge where a hazard bubble is inserted, saturates at 16'hFFFF, and is cleared by reset. Flush bubbles are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH) and ALUOp encodings (ALUOP_ADD=00, ALUOP_BR=01, ALUOP_R=10). The EX-side ALU control decoder uses the same ALUOp encodings.
- One sub-module: id_imm_gen (combinational instr -> XLEN immediate, format chosen from opcode).

Test Plan:
- add x3,x1,x2 (0x002081B3), valid, no stall -> next edge ex_ALUOp=10, ex_Funct=0000, RegWrite=1, ALUSrc=0, ex_rd=3, ex_valid=1.
- sub x5,x6,x7 then slli x4,x4,3 -> ex_Funct=1000 with ALUOp=10, then ex_Funct=0001 with ALUOp=00, ALUSrc=1, ex_imm=3.
- ld x5,-8(x1) then add x6,x5,x2 -> hazard_stall=1 for one cycle, one bubble (ex_valid=0, RegWrite=0), then the add issues. bubble_count=1 with BUBBLE_CNT_EN.
- beq x1,x2,-4 (0xFE208EE3) -> ALUOp=01, Branch=1, ex_rd=0, ex_imm=0xFFFF_FFFF_FFFF_FFFC.
- Load-use pending plus flush_in=1 on same cycle -> hazard_stall=0, ex_valid=0. Separately, stall_in=1 for 3 cycles -> ex_* unchanged across all three.
- Opcode 0x7F -> ex_illegal=1, all control bits 0. Assert reset low mid-stream -> all ex_* =0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/id_ex_ctrl_stage_pkg.sv
`default_nettype none
// Shared decode constants for the ID stage and the EX-side ALU control decoder.
package id_ex_ctrl_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_zero;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R: begin
        c.alu_op    = ALUOP_R;
        c.reg_write = 1'b1;
        c.rs1_used  = 1'b1;
        c.rs2_used  = 1'b1;
      end
      OP_IMM: begin
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.rs1_used  = 1'b1;
      end
      OP_LOAD: begin
        c.alu_op     = ALUOP_ADD;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.rs1_used   = 1'b1;
      end
      OP_STORE: begin
        c.alu_op    = ALUOP_ADD;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.rs1_used  = 1'b1;
        c.rs2_used  = 1'b1;
        c.rd_zero   = 1'b1;
      end
      OP_BRANCH: begin
        c.alu_op   = ALUOP_BR;
        c.branch   = 1'b1;
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.rd_zero  = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_ctrl_stage_imm_gen.sv
`default_nettype none
// id_imm_gen: combinational I/S/B immediate extraction, sign-extended to XLEN.
module id_imm_gen
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [12:0] imm13;
  logic        unused_bits;

  // All formats fit a 13-bit signed value; B carries the implicit zero LSB.
  always_comb begin
    imm13 = '0;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD: imm13 = {instr_i[31], instr_i[31:20]};
      OP_STORE:        imm13 = {instr_i[31], instr_i[31:25], instr_i[11:7]};
      OP_BRANCH:       imm13 = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      default:         imm13 = '0;
    endcase
  end

  assign imm_o       = {{(XLEN-13){imm13[12]}}, imm13};
  assign unused_bits = ^instr_i[19:12];

endmodule
`default_nettype wire

// File: rtl/id_ex_ctrl_stage.sv
`default_nettype none
// ID decode and ID/EX pipeline register with load-use interlock and stall/flush.
// Optional: define BUBBLE_CNT_EN to add the saturating bubble_count output.
module id_ex_ctrl_stage
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instr,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [1:0]         ex_ALUOp,
  output logic [FUNCT_W-1:0] ex_Funct,
  output logic               ex_Branch,
  output logic               ex_MemRead,
  output logic               ex_MemtoReg,
  output logic               ex_MemWrite,
  output logic               ex_ALUSrc,
  output logic               ex_RegWrite,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic [XLEN-1:0]    ex_imm,
`ifdef BUBBLE_CNT_EN
  output logic [15:0]        bubble_count,
`endif
  output logic               ex_illegal
);

  typedef struct packed {
    logic               valid;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               illegal;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
  } idex_t;

  idex_t           idex_d, idex_q;
  ctrl_t           dec;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1, rs2;
  logic            hazard_raw;

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (if_id_instr),
    .imm_o   (imm)
  );

  assign dec = decode_ctrl(if_id_instr[6:0]);
  assign rs1 = if_id_instr[19:15];
  assign rs2 = if_id_instr[24:20];

  assign hazard_raw = if_id_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd0)
                    & dec.rs1_used
                    & ((idex_q.rd == rs1) | (dec.rs2_used & (idex_q.rd == rs2)));
  assign hazard_stall = hazard_raw & ~flush_in & ~stall_in;

  always_comb begin
    idex_d = idex_q;
    if (flush_in) begin
      idex_d = '0;
    end else if (stall_in) begin
      idex_d = idex_q;
    end else if (hazard_stall) begin
      idex_d = '0;
    end else begin
      idex_d       = '0;
      idex_d.valid = if_id_valid;
      idex_d.funct = {if_id_instr[30], if_id_instr[14:12]};
      idex_d.rs1   = rs1;
      idex_d.rs2   = dec.rs2_used ? rs2 : 5'd0;
      idex_d.rd    = dec.rd_zero ? 5'd0 : if_id_instr[11:7];
      idex_d.imm   = imm;
      // Controls of a non-valid slot stay zero so a bubble never writes state.
      if (if_id_valid) begin
        idex_d.alu_op     = dec.alu_op;
        idex_d.branch     = dec.branch;
        idex_d.mem_read   = dec.mem_read;
        idex_d.mem_to_reg = dec.mem_to_reg;
        idex_d.mem_write  = dec.mem_write;
        idex_d.alu_src    = dec.alu_src;
        idex_d.reg_write  = dec.reg_write;
        idex_d.illegal    = dec.illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

`ifdef BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (hazard_stall && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_count = bubble_cnt_q;
`endif

  assign ex_valid    = idex_q.valid;
  assign ex_ALUOp    = idex_q.alu_op;
  assign ex_Funct    = idex_q.funct;
  assign ex_Branch   = idex_q.branch;
  assign ex_MemRead  = idex_q.mem_read;
  assign ex_MemtoReg = idex_q.mem_to_reg;
  assign ex_MemWrite = idex_q.mem_write;
  assign ex_ALUSrc   = idex_q.alu_src;
  assign ex_RegWrite = idex_q.reg_write;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_rd       = idex_q.rd;
  assign ex_imm      = idex_q.imm;
  assign ex_illegal  = idex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_ctrl_stage.sv
`default_nettype none
// Randomized self-checking bench for id_ex_ctrl_stage against an instruction-level model.
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic        stall_in, flush_in;
  logic        hazard_stall, ex_valid;
  logic [1:0]  ex_ALUOp;
  logic [3:0]  ex_Funct;
  logic        ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [63:0] ex_imm;
  logic        ex_illegal;
`ifdef BUBBLE_CNT_EN
  logic [15:0] bubble_count;
`endif

  id_ex_ctrl_stage #(.XLEN(64), .FUNCT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_ALUOp     (ex_ALUOp),
    .ex_Funct     (ex_Funct),
    .ex_Branch    (ex_Branch),
    .ex_MemRead   (ex_MemRead),
    .ex_MemtoReg  (ex_MemtoReg),
    .ex_MemWrite  (ex_MemWrite),
    .ex_ALUSrc    (ex_ALUSrc),
    .ex_RegWrite  (ex_RegWrite),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_imm       (ex_imm),
`ifdef BUBBLE_CNT_EN
    .bubble_count (bubble_count),
`endif
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: which instruction currently sits in EX, and whether it is real.
  logic        m_valid;
  logic [31:0] m_instr;
  int          m_bubbles;
  logic        last_haz;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_op(input logic [31:0] i, input logic [6:0] op);
    return i[6:0] == op;
  endfunction

  function automatic bit legal(input logic [31:0] i);
    return is_op(i, 7'h33) || is_op(i, 7'h13) || is_op(i, 7'h03) || is_op(i, 7'h23) || is_op(i, 7'h63);
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    return is_op(i, 7'h33) || is_op(i, 7'h23) || is_op(i, 7'h63);
  endfunction

  // {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
  function automatic logic [5:0] exp_ctrl(input logic [31:0] i);
    if (is_op(i, 7'h33)) return 6'b000001;
    if (is_op(i, 7'h13)) return 6'b000011;
    if (is_op(i, 7'h03)) return 6'b011011;
    if (is_op(i, 7'h23)) return 6'b000110;
    if (is_op(i, 7'h63)) return 6'b100000;
    return 6'b000000;
  endfunction

  function automatic logic [1:0] exp_aluop(input logic [31:0] i);
    if (is_op(i, 7'h33)) return 2'd2;
    if (is_op(i, 7'h63)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] exp_imm(input logic [31:0] i);
    longint v;
    longint s;
    s = i[31] ? 64'sd4096 : 64'sd0;
    v = 0;
    if (is_op(i, 7'h13) || is_op(i, 7'h03))
      v = longint'(i[31:20]) - s;
    else if (is_op(i, 7'h23))
      v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - s;
    else if (is_op(i, 7'h63))
      v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2 - s;
    return 64'(v);
  endfunction

  function automatic logic [4:0] exp_rd(input logic [31:0] i);
    if (is_op(i, 7'h23) || is_op(i, 7'h63)) return 5'd0;
    return i[11:7];
  endfunction

  function automatic bit model_hazard(input logic v, input logic [31:0] i, input logic st, input logic fl);
    logic [4:0] rd;
    rd = exp_rd(m_instr);
    if (!(m_valid && is_op(m_instr, 7'h03) && rd != 5'd0 && v && legal(i) && !st && !fl)) return 1'b0;
    return (rd == i[19:15]) || (uses_rs2(i) && rd == i[24:20]);
  endfunction

  task automatic check_outputs();
    logic [5:0] c;
    c = {ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite};
    chk_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
    if (!m_valid) begin
      chk_eq("bubble_ctrl", 64'(c), 64'd0);
    end else begin
      chk_eq("ctrl", 64'(c), 64'(exp_ctrl(m_instr)));
      chk_eq("aluop", 64'(ex_ALUOp), 64'(exp_aluop(m_instr)));
      chk_eq("funct", 64'(ex_Funct), 64'({m_instr[30], m_instr[14:12]}));
      chk_eq("illegal", 64'(ex_illegal), 64'(!legal(m_instr)));
      if (legal(m_instr)) begin
        chk_eq("imm", ex_imm, exp_imm(m_instr));
        chk_eq("rd", 64'(ex_rd), 64'(exp_rd(m_instr)));
        chk_eq("rs1", 64'(ex_rs1), 64'(m_instr[19:15]));
        if (uses_rs2(m_instr)) chk_eq("rs2", 64'(ex_rs2), 64'(m_instr[24:20]));
      end
    end
`ifdef BUBBLE_CNT_EN
    chk_eq("bubble_count", 64'(bubble_count), 64'(m_bubbles));
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bit eh;
    @(negedge clk);
    if_id_valid = v;
    if_id_instr = ins;
    stall_in    = st;
    flush_in    = fl;
    #1;
    eh = model_hazard(v, ins, st, fl);
    chk_eq("hazard_stall", 64'(hazard_stall), 64'(eh));
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (eh) begin
      m_valid = 1'b0;
      if (m_bubbles < 65535) m_bubbles++;
    end else begin
      m_valid = v;
      m_instr = ins;
    end
    last_haz = eh;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_zero(input string tag);
    chk_eq({tag, "_valid"}, 64'(ex_valid), 64'd0);
    chk_eq({tag, "_ctrl"}, 64'({ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite}), 64'd0);
    chk_eq({tag, "_imm"}, ex_imm, 64'd0);
    chk_eq({tag, "_rd"}, 64'(ex_rd), 64'd0);
    chk_eq({tag, "_aluop"}, 64'(ex_ALUOp), 64'd0);
    chk_eq({tag, "_hazard"}, 64'(hazard_stall), 64'd0);
  endtask

  logic [31:0] r_ins;

  initial begin
    reset = 1'b0; if_id_valid = 1'b0; if_id_instr = '0; stall_in = 1'b0; flush_in = 1'b0;
    m_valid = 1'b0; m_instr = '0; m_bubbles = 0; last_haz = 1'b0;
    #3;
    check_reset_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed sequence
    step(1, 32'h002081B3, 0, 0);             // add x3,x1,x2
    chk_eq("add_rd", 64'(ex_rd), 64'd3);
    step(1, 32'h407302B3, 0, 0);             // sub x5,x6,x7
    chk_eq("sub_funct", 64'(ex_Funct), 64'h8);
    step(1, 32'h00321213, 0, 0);             // slli x4,x4,3
    chk_eq("slli_imm", ex_imm, 64'd3);
    step(1, 32'hFF80B283, 0, 0);             // ld x5,-8(x1)
    step(1, 32'h00228333, 0, 0);             // add x6,x5,x2 -> bubble
    chk_eq("lu_bubble", 64'(ex_valid), 64'd0);
    step(1, 32'h00228333, 0, 0);             // held add issues
    chk_eq("lu_issue_rd", 64'(ex_rd), 64'd6);
    step(1, 32'hFE208EE3, 0, 0);             // beq x1,x2,-4
    chk_eq("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 32'hFF80B283, 0, 0);             // ld, then use with flush
    step(1, 32'h00228333, 0, 1);
    step(1, 32'h00321213, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 32'h002081B3, 1, 0);
    chk_eq("stall_imm_held", ex_imm, 64'd3);
    step(1, 32'h0000007F, 0, 0);             // illegal opcode
    chk_eq("illegal_flag", 64'(ex_illegal), 64'd1);
    step(1, 32'hFF80B283, 0, 0);

    // Reset mid-stream: outputs clear before the next edge
    @(negedge clk);
    if_id_valid = 1'b1; if_id_instr = 32'h00228333; stall_in = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_zero("async_reset");
    m_valid = 1'b0; m_instr = '0; m_bubbles = 0; stall_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1, 32'h002081B3, 0, 0);

    // Randomized traffic with a small register pool so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      bit v, st, fl;
      if (!last_haz) begin
        case ($urandom_range(0, 6))
          0: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h33;
          1: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h13;
          2, 3: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h03;
          4: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h23;
          5: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h63;
          default: r_ins = {$urandom} & 32'hFFFF_FF80 | 32'h37;
        endcase
        r_ins[11:7]  = 5'($urandom_range(0, 3));
        r_ins[19:15] = 5'($urandom_range(0, 3));
        r_ins[24:20] = 5'($urandom_range(0, 3));
      end
      v  = ($urandom_range(0, 99) < 85);
      st = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 8);
      step(v, r_ins, st, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
